present_inv_key_schedule: RTL

- Sequential PRESENT-80 decryption key scheduler.
- Accepts an 80-bit master key and rolls the forward key schedule ROUNDS times to reach the final register state.
- Then streams the round keys in reverse order (K[ROUNDS+1] down to K1) using the inverse update step.
- Feeds the decryption datapath, which consumes one round key per handshake; it is the counterpart of the forward per-round key update used by encryption.

---
 rtl/present_inv_key_schedule.sv | 122 ++++++++++++
 1 files changed

// File: rtl/present_inv_key_schedule.sv
// PRESENT-80 decryption key scheduler: rolls the forward schedule to the last
// round key, then streams round keys back down to K1 using the inverse update.
module present_inv_key_schedule #(
  parameter int ROUNDS = 31,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [79:0]      key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] FIRST = IDX_W'(ROUNDS + 1);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  state_t           state;
  logic [79:0]      key_reg;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_dec;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // rotl 61, S-box on top nibble, round counter into bits 19:15
  function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ i;
    fwd_step   = t;
  endfunction

  // exact undo of fwd_step: counter, inverse S-box, then rotr 61
  function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ i;
    t[79:76]   = sbox_inv(t[79:76]);
    inv_step   = {t[60:0], t[79:61]};
  endfunction

  assign idx_dec = rk_idx - ONE;
  assign rk_out  = key_reg[79:16];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      cnt       <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
            key_reg   <= key_in;
            cnt       <= ONE;
            state     <= FWD;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FWD: begin
          key_reg <= fwd_step(key_reg, cnt[4:0]);
          cnt     <= cnt + ONE;
          if (cnt == LAST) begin
            state    <= EMIT;
            rk_valid <= 1'b1;
            rk_idx   <= FIRST;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rk_idx == ONE) begin
              state     <= IDLE;
              rk_valid  <= 1'b0;
              rk_idx    <= '0;
              cnt       <= '0;
              done      <= 1'b1;
              key_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              key_reg <= inv_step(key_reg, idx_dec[4:0]);
              rk_idx  <= idx_dec;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
